// File: rtl/srcnn_mac_pkg.sv
// Shared definitions for the SRCNN multiply-accumulate datapath.
//   MIN_NUM_STAGE : smallest legal input-to-output latency
//   ext_width()   : operand width after the leading sign/zero bit is added
//   prod_width()  : width of the signed product of two extended operands
//   ovf_mode()    : picks signed or unsigned overflow detection
package srcnn_mac_pkg;

    localparam int unsigned MIN_NUM_STAGE = 2;

    typedef enum logic {
        OVF_SIGNED,
        OVF_UNSIGNED
    } ovf_mode_e;

    function automatic int unsigned ext_width(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
        return ext_width(w0) + ext_width(w1);
    endfunction

    function automatic ovf_mode_e ovf_mode(input int unsigned s0, input int unsigned s1);
        return ((s0 != 0) || (s1 != 0)) ? OVF_SIGNED : OVF_UNSIGNED;
    endfunction

endpackage

// File: rtl/srcnn_mul_pipe.sv
// Operand extension, signed multiply and NUM_MUL enable-gated register
// stages carrying the product plus valid/first/last side-band.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   en_i            : advance all stages (low = hold)
//   valid_i/first_i/last_i, din0_i, din1_i : accepted input beat
//   valid_o/first_o/last_o, prod_o         : last stage contents
module srcnn_mul_pipe
    import srcnn_mac_pkg::*;
#(
    parameter int unsigned NUM_MUL = 2,
    parameter int unsigned W0      = 14,
    parameter int unsigned W1      = 12,
    parameter int unsigned S0      = 0,
    parameter int unsigned S1      = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 en_i,
    input  logic                                 valid_i,
    input  logic                                 first_i,
    input  logic                                 last_i,
    input  logic [W0-1:0]                        din0_i,
    input  logic [W1-1:0]                        din1_i,
    output logic                                 valid_o,
    output logic                                 first_o,
    output logic                                 last_o,
    output logic signed [prod_width(W0, W1)-1:0] prod_o
);

    localparam int unsigned PW = prod_width(W0, W1);

    logic signed [W0:0]    a_ext;
    logic signed [W1:0]    b_ext;
    logic signed [PW-1:0]  a_pw, b_pw, prod_c;

    logic [NUM_MUL-1:0][PW-1:0] prod_q;
    logic [NUM_MUL-1:0]         vld_q, first_q, last_q;

    // Operands are widened to the full product width first so the multiply
    // is evaluated entirely in signed PW-bit arithmetic.
    always_comb begin
        a_ext  = {((S0 != 0) ? din0_i[W0-1] : 1'b0), din0_i};
        b_ext  = {((S1 != 0) ? din1_i[W1-1] : 1'b0), din1_i};
        a_pw   = PW'(a_ext);
        b_pw   = PW'(b_ext);
        prod_c = a_pw * b_pw;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prod_q  <= '0;
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else if (en_i) begin
            prod_q[0]  <= prod_c;
            vld_q[0]   <= valid_i;
            first_q[0] <= first_i;
            last_q[0]  <= last_i;
            for (int unsigned i = 1; i < NUM_MUL; i++) begin
                prod_q[i]  <= prod_q[i-1];
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    always_comb begin
        valid_o = vld_q[NUM_MUL-1];
        first_o = first_q[NUM_MUL-1];
        last_o  = last_q[NUM_MUL-1];
        prod_o  = prod_q[NUM_MUL-1];
    end

endmodule

// File: rtl/srcnn_mac_pipe_p.sv
// Pipelined multiply-accumulate for the SRCNN convolution datapath.
// Sums one kernel-window dot product per group (in_first .. in_last) and
// emits it with a sticky overflow flag. Valid/ready on both sides; a single
// global stall (result held, downstream not ready) freezes every stage.
//   ap_clk, ap_rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready           : input handshake
//   din0, din1                  : pixel / weight operands
//   in_first, in_last           : group delimiters
//   out_valid/out_ready         : output handshake
//   dout, dout_ovf              : group sum (mod 2^ACC_WIDTH), overflow flag
module srcnn_mac_pipe_p
    import srcnn_mac_pkg::*;
#(
    parameter int          ID         = 1,
    parameter int unsigned NUM_STAGE  = 3,
    parameter int unsigned din0_WIDTH = 14,
    parameter int unsigned din1_WIDTH = 12,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned SIGNED0    = 0,
    parameter int unsigned SIGNED1    = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  dout_ovf
);

    localparam int unsigned PW       = prod_width(din0_WIDTH, din1_WIDTH);
    localparam int unsigned AW1      = ACC_WIDTH + 1;
    localparam ovf_mode_e   OVF_MODE = ovf_mode(SIGNED0, SIGNED1);

    if (NUM_STAGE < MIN_NUM_STAGE) begin : g_chk_stage
        $error("srcnn_mac_pipe_p: NUM_STAGE must be >= 2");
    end
    if (ACC_WIDTH < din0_WIDTH + din1_WIDTH) begin : g_chk_acc
        $error("srcnn_mac_pipe_p: ACC_WIDTH must be >= din0_WIDTH + din1_WIDTH");
    end
    if (ID < 0) begin : g_chk_id
        $error("srcnn_mac_pipe_p: ID must be non-negative");
    end

    logic                  stall, adv, accept;
    logic                  mul_vld, mul_first, mul_last;
    logic signed [PW-1:0]  mul_prod;

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic                  acc_last_q, acc_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  dout_q, dout_d;
    logic                  dout_ovf_q, dout_ovf_d;

    logic signed [AW1-1:0] prod_ext, acc_ext, sum;
    logic                  step_ovf;

    always_comb begin
        stall    = out_valid_q && !out_ready;
        adv      = !stall;
        in_ready = adv;
        accept   = in_valid && adv;
    end

    srcnn_mul_pipe #(
        .NUM_MUL (NUM_STAGE - 1),
        .W0      (din0_WIDTH),
        .W1      (din1_WIDTH),
        .S0      (SIGNED0),
        .S1      (SIGNED1)
    ) u_mul (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .en_i    (adv),
        .valid_i (accept),
        .first_i (in_first),
        .last_i  (in_last),
        .din0_i  (din0),
        .din1_i  (din1),
        .valid_o (mul_vld),
        .first_o (mul_first),
        .last_o  (mul_last),
        .prod_o  (mul_prod)
    );

    // Sum is formed one bit wider than the accumulator: the extra bit is the
    // carry (unsigned) or lets the top two bits disagree on signed overflow.
    // The product always fits in ACC_WIDTH, so a first beat never overflows.
    always_comb begin
        prod_ext = AW1'(mul_prod);
        if (OVF_MODE == OVF_SIGNED) begin
            acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
        end else begin
            acc_ext = {1'b0, acc_q};
        end
        sum = acc_ext + prod_ext;
        if (OVF_MODE == OVF_SIGNED) begin
            step_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        end else begin
            step_ovf = sum[ACC_WIDTH];
        end

        acc_d      = acc_q;
        ovf_d      = ovf_q;
        acc_last_d = mul_vld && mul_last;
        if (mul_vld) begin
            if (mul_first) begin
                acc_d = prod_ext[ACC_WIDTH-1:0];
                ovf_d = 1'b0;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
                ovf_d = ovf_q | step_ovf;
            end
        end

        // The output register samples the accumulator one cycle after the
        // last beat updates it; a following first beat overwrites acc_q at
        // that same edge, so no bubble is needed between groups.
        out_valid_d = acc_last_q;
        dout_d      = dout_q;
        dout_ovf_d  = dout_ovf_q;
        if (acc_last_q) begin
            dout_d     = acc_q;
            dout_ovf_d = ovf_q;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_ovf_q  <= 1'b0;
        end else if (adv) begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            acc_last_q  <= acc_last_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            dout_ovf_q  <= dout_ovf_d;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        dout      = dout_q;
        dout_ovf  = dout_ovf_q;
    end

endmodule

// File: tb/tb_srcnn_mac_pipe_p.sv
module tb_srcnn_mac_pipe_p;

    localparam int     W0   = 14;
    localparam int     W1   = 12;
    localparam int     AW   = 26;
    localparam int     NS   = 3;
    localparam longint MOD  = longint'(1) << AW;
    localparam longint SMAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (AW - 1));

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W0-1:0] din0 = '0;
    logic [W1-1:0] din1 = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready_u, out_valid_u, dout_ovf_u;
    logic [AW-1:0] dout_u;
    logic          in_ready_s, out_valid_s, dout_ovf_s;
    logic [AW-1:0] dout_s;

    // Unsigned-mode instance and mixed-signedness (signed weight) instance
    // share the same stimulus and handshake.
    srcnn_mac_pipe_p #(
        .ID(1), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
        .ACC_WIDTH(AW), .SIGNED0(0), .SIGNED1(0)
    ) u_dut_u (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_u), .out_ready(out_ready), .dout(dout_u), .dout_ovf(dout_ovf_u)
    );

    srcnn_mac_pipe_p #(
        .ID(2), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
        .ACC_WIDTH(AW), .SIGNED0(0), .SIGNED1(1)
    ) u_dut_s (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s), .dout_ovf(dout_ovf_s)
    );

    always #5 ap_clk = ~ap_clk;

    longint cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint da;
        bit     oa;
        longint db;
        bit     ob;
        longint t_acc;
        bit     chk_lat;
        bit     seen;
    } exp_t;

    exp_t   q[$];
    longint m_acc_u = 0;
    longint m_acc_s = 0;
    bit     m_ovf_u = 0;
    bit     m_ovf_s = 0;
    bit     rand_rdy = 0;
    bit     lat_next = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic per beat, wrapped to AW bits.
    task automatic model_beat(input logic [W0-1:0] a, input logic [W1-1:0] b,
                              input bit f, input bit l, input longint t);
        longint pu, ps, sb, t2, w;
        exp_t   e;
        sb = longint'(b);
        if (b[W1-1]) sb = sb - (longint'(1) << W1);
        pu = longint'(a) * longint'(b);
        ps = longint'(a) * sb;
        if (f) begin
            m_acc_u = pu;
            m_ovf_u = 0;
            m_acc_s = ps;
            m_ovf_s = 0;
        end else begin
            t2 = m_acc_u + pu;
            if (t2 >= MOD) m_ovf_u = 1;
            m_acc_u = t2 % MOD;
            t2 = m_acc_s + ps;
            if (t2 > SMAX || t2 < SMIN) m_ovf_s = 1;
            w = t2 % MOD;
            if (w < 0) w = w + MOD;
            if (w > SMAX) w = w - MOD;
            m_acc_s = w;
        end
        if (l) begin
            e.da = m_acc_u;
            e.oa = m_ovf_u;
            e.db = m_acc_s & (MOD - 1);
            e.ob = m_ovf_s;
            e.t_acc = t;
            e.chk_lat = lat_next;
            e.seen = 0;
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [W0-1:0] a, input logic [W1-1:0] b, input bit f, input bit l);
        int unsigned n;
        bit taken;
        n = 0;
        taken = 0;
        in_valid = 1'b1;
        din0 = a;
        din1 = b;
        in_first = f;
        in_last = l;
        while (!taken && n < 200) begin
            @(posedge ap_clk);
            n++;
            if (in_ready_u) taken = 1;
        end
        if (taken) model_beat(a, b, f, l, cyc);
        else chk("accept_timeout", longint'(in_ready_u), 1);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((q.size() != 0 || out_valid_u) && n < 2000) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", q.size(), 0);
        repeat (2) @(negedge ap_clk);
    endtask

    // Monitor: compare whatever the DUTs present against the queue head;
    // pop only when the result is actually consumed.
    always @(negedge ap_clk) begin
        if (ap_rst_n && (out_valid_u || out_valid_s)) begin
            if (q.size() == 0) begin
                chk("spurious_out", longint'(out_valid_u | out_valid_s), 0);
            end else begin
                chk("out_valid_u", longint'(out_valid_u), 1);
                chk("out_valid_s", longint'(out_valid_s), 1);
                chk("dout_u", longint'(dout_u), q[0].da);
                chk("ovf_u", longint'(dout_ovf_u), longint'(q[0].oa));
                chk("dout_s", longint'(dout_s), q[0].db);
                chk("ovf_s", longint'(dout_ovf_s), longint'(q[0].ob));
                if (!q[0].seen) begin
                    q[0].seen = 1;
                    if (q[0].chk_lat) chk("latency", cyc - q[0].t_acc - 1, NS);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    always @(posedge ap_clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [W0-1:0] ra;
        logic [W1-1:0] rb;
        int unsigned   len;
        bit            nofirst;

        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_out_valid_u", longint'(out_valid_u), 0);
        chk("rst_dout_u", longint'(dout_u), 0);
        chk("rst_ovf_u", longint'(dout_ovf_u), 0);
        chk("rst_in_ready_u", longint'(in_ready_u), 1);
        chk("rst_out_valid_s", longint'(out_valid_s), 0);
        chk("rst_dout_s", longint'(dout_s), 0);
        chk("rst_ovf_s", longint'(dout_ovf_s), 0);
        chk("rst_in_ready_s", longint'(in_ready_s), 1);

        // Last without a preceding first: continues from acc = 0.
        send(14'd3, 12'd5, 0, 1);
        wait_idle();

        lat_next = 1;
        send(14'd100, 12'd50, 1, 1);
        lat_next = 0;
        wait_idle();

        send(14'd7, 12'hFFD, 1, 1);
        wait_idle();

        // Back-to-back groups; latency check on both shows no bubble.
        lat_next = 1;
        send(14'd1, 12'd2, 1, 0);
        send(14'd3, 12'd4, 0, 0);
        send(14'd5, 12'd6, 0, 0);
        send(14'd7, 12'd8, 0, 1);
        send(14'd10, 12'd10, 1, 1);
        lat_next = 0;
        wait_idle();

        // Overflow groups, then a clean group to confirm the flag clears.
        for (int i = 0; i < 3; i++) send(14'h3FFF, 12'hFFF, i == 0, i == 2);
        send(14'd2, 12'd3, 1, 1);
        for (int i = 0; i < 3; i++) send(14'h3FFF, 12'h7FF, i == 0, i == 2);
        send(14'h3FFF, 12'h800, 1, 0);
        send(14'h3FFF, 12'h800, 0, 1);
        wait_idle();

        // Downstream stall while six single-beat groups are offered.
        @(posedge ap_clk);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(14'(i + 1), 12'(i + 20), 1, 1);
            end
            begin
                repeat (4) @(posedge ap_clk);
                repeat (5) begin
                    @(negedge ap_clk);
                    chk("stall_in_ready_u", longint'(in_ready_u), 0);
                    chk("stall_in_ready_s", longint'(in_ready_s), 0);
                end
                @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset after two beats of a group, then a fresh single-beat group.
        send(14'd5, 12'd5, 1, 0);
        send(14'd6, 12'd6, 0, 0);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        m_acc_u = 0; m_ovf_u = 0; m_acc_s = 0; m_ovf_s = 0;
        @(negedge ap_clk);
        chk("midrst_out_valid", longint'(out_valid_u), 0);
        send(14'd9, 12'd9, 1, 1);
        wait_idle();

        // Reset with a last beat in flight: its result must never appear,
        // and the accumulator restarts from zero.
        send(14'd11, 12'd11, 1, 0);
        send(14'd12, 12'd12, 0, 1);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        q.delete();
        m_acc_u = 0; m_ovf_u = 0; m_acc_s = 0; m_ovf_s = 0;
        repeat (8) @(negedge ap_clk);
        send(14'd4, 12'd4, 0, 1);
        wait_idle();

        // Randomized groups with random downstream back-pressure.
        rand_rdy = 1;
        for (int g = 0; g < 60; g++) begin
            len = $urandom_range(1, 6);
            nofirst = ($urandom_range(0, 9) == 0);
            for (int unsigned i = 0; i < len; i++) begin
                ra = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
                case ($urandom_range(0, 4))
                    0: rb = 12'hFFF;
                    1: rb = 12'h7FF;
                    2: rb = 12'h800;
                    default: rb = 12'($urandom);
                endcase
                send(ra, rb, (i == 0) && !nofirst, i == len - 1);
            end
        end
        rand_rdy = 0;
        @(posedge ap_clk);
        #2 out_ready = 1'b1;
        wait_idle();
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
